// File: rtl/pow4_lane_sched.sv
// pow4_lane_sched
// Round-robin scheduler that lets NUM_LANES sample streams share one pow_4
// instance ((I+jQ)^4). The lane tag of each sample follows pow_4's
// valid-advanced two-register pipeline. When no lane is requesting, a zero
// bubble pushes the last sample out of pow_4, and its result is returned
// with the lane index it came from.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_lane_valid          per-lane request
//   i_lane_data_i/_q      packed lane samples, lane n at [n*NBW_IN +: NBW_IN]
//   o_lane_ready          one-hot grant (combinational)
//   o_p4_valid/_data_*    drive pow_4 inputs (data is 0 on a bubble)
//   i_p4_data_i/_q        pow_4 outputs
//   o_res_valid/_lane     result strobe and the lane index of the result
//   o_res_data_i/_q       pow_4 result while o_res_valid, otherwise 0
module pow4_lane_sched #(
  parameter int NUM_LANES  = 4,
  parameter int NBW_IN     = 9,
  parameter int NBW_OUT    = 9,
  parameter int FLUSH_WAIT = 0,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        i_lane_valid,
  input  logic [NUM_LANES*NBW_IN-1:0] i_lane_data_i,
  input  logic [NUM_LANES*NBW_IN-1:0] i_lane_data_q,
  output logic [NUM_LANES-1:0]        o_lane_ready,
  output logic                        o_p4_valid,
  output logic [NBW_IN-1:0]           o_p4_data_i,
  output logic [NBW_IN-1:0]           o_p4_data_q,
  input  logic [NBW_OUT-1:0]          i_p4_data_i,
  input  logic [NBW_OUT-1:0]          i_p4_data_q,
  output logic                        o_res_valid,
  output logic [LW-1:0]               o_res_lane,
  output logic [NBW_OUT-1:0]          o_res_data_i,
  output logic [NBW_OUT-1:0]          o_res_data_q
);

  localparam int CW = (FLUSH_WAIT > 0) ? $clog2(FLUSH_WAIT + 1) : 1;
  localparam logic [LW:0]   NL   = (LW+1)'(NUM_LANES);
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);
  localparam logic [CW-1:0] FW   = CW'(FLUSH_WAIT);

  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] gnt_idx;
  logic [LW-1:0] scan_idx;
  logic [LW:0]   scan_sum;
  logic          any_req;
  logic          bubble;
  logic          advance;
  logic          s1_v;
  logic [LW-1:0] s1_lane;
  logic [LW-1:0] s2_lane;
  logic          res_vld;
  logic [CW-1:0] idle_cnt;

  // Scan from the farthest offset down to offset 0 so the lane closest to
  // the rr pointer (wrapping) is the last one written, i.e. it wins.
  always_comb begin
    any_req  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (LW+1)'(k);
      if (scan_sum >= NL) scan_sum = scan_sum - NL;
      scan_idx = scan_sum[LW-1:0];
      if (i_lane_valid[scan_idx]) begin
        any_req = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // A request always beats a pending flush, so a bubble only fills a
  // cycle that would otherwise be empty.
  assign bubble  = ~any_req & s1_v & (idle_cnt == FW);
  assign advance = any_req | bubble;

  assign o_lane_ready = any_req ? (NUM_LANES'(1) << gnt_idx) : '0;
  assign o_p4_valid   = advance;
  assign o_p4_data_i  = any_req ? i_lane_data_i[gnt_idx*NBW_IN +: NBW_IN] : '0;
  assign o_p4_data_q  = any_req ? i_lane_data_q[gnt_idx*NBW_IN +: NBW_IN] : '0;

  // s2 holds the lane of the result now on pow_4's output; its validity is
  // res_vld, which is only set on the edge that actually moved a sample there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_v     <= 1'b0;
      s1_lane  <= '0;
      s2_lane  <= '0;
      res_vld  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      res_vld <= advance & s1_v;
      if (any_req) rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      if (advance) begin
        s1_v     <= any_req;
        s1_lane  <= gnt_idx;
        s2_lane  <= s1_lane;
        idle_cnt <= '0;
      end else if (s1_v && (idle_cnt != FW)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign o_res_valid  = res_vld;
  assign o_res_lane   = s2_lane;
  assign o_res_data_i = res_vld ? i_p4_data_i : '0;
  assign o_res_data_q = res_vld ? i_p4_data_q : '0;

endmodule
